// File: rtl/mux4_reg_pkg.sv
// Shared types and helpers for the registered 4:1 multiplexer.
package mux4_reg_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    SEL_D0 = 2'b00,
    SEL_D1 = 2'b01,
    SEL_D2 = 2'b10,
    SEL_D3 = 2'b11
  } sel_e;

  // s1 is the select MSB, s0 the LSB.
  function automatic sel_e sel_of(input logic s1, input logic s0);
    return sel_e'({s1, s0});
  endfunction

endpackage

// File: rtl/mux4_comb.sv
// Purely combinational WIDTH-bit 4:1 selector; every select code maps to an input.
module mux4_comb
  import mux4_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  sel_e             sel,
  output logic [WIDTH-1:0] o
);

  always_comb begin
    o = d0;
    unique case (sel)
      SEL_D0: o = d0;
      SEL_D1: o = d1;
      SEL_D2: o = d2;
      SEL_D3: o = d3;
    endcase
  end

endmodule

// File: rtl/mux4_reg.sv
// Registered 4:1 mux with one cycle of latency and a per-load valid strobe.
// Defining MUX4_REG_PARITY_EN adds y_par, the even parity of the loaded word.
module mux4_reg
  import mux4_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic             s0,
  input  logic             s1,
`ifdef MUX4_REG_PARITY_EN
  output logic             y_par,
`endif
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);

  // Handshake: y_valid is a one-cycle strobe with no ready; it is high in the
  // cycle after an edge that loaded y, and the consumer must take y then.
  sel_e             sel;
  logic [WIDTH-1:0] mux_o;

  logic [WIDTH-1:0] y_d, y_q;
  logic             y_valid_d, y_valid_q;

  assign sel = sel_of(s1, s0);

  mux4_comb #(.WIDTH(WIDTH)) u_mux (
    .d0  (d0),
    .d1  (d1),
    .d2  (d2),
    .d3  (d3),
    .sel (sel),
    .o   (mux_o)
  );

  always_comb begin
    y_d       = y_q;
    y_valid_d = 1'b0;
    if (en) begin
      y_d       = mux_o;
      y_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;

`ifdef MUX4_REG_PARITY_EN
  logic y_par_d, y_par_q;

  // Parity follows the same load/hold rule as y so the pair stays coherent.
  always_comb begin
    y_par_d = y_par_q;
    if (en) y_par_d = ^mux_o;
  end

  always_ff @(posedge clk) begin
    if (rst) y_par_q <= 1'b0;
    else     y_par_q <= y_par_d;
  end

  assign y_par = y_par_q;
`endif

endmodule

// File: tb/tb_mux4_reg.sv
// Self-checking bench for mux4_reg: directed vectors plus an array-based reference model.
module tb_mux4_reg;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, en, s0, s1;
  logic [W-1:0] d0, d1, d2, d3;
  logic [W-1:0] y;
  logic         y_valid;
`ifdef MUX4_REG_PARITY_EN
  logic         y_par;
`endif

  int checks = 0;
  int errors = 0;

  // Expected queue entries are {valid, parity, y}.
  logic [W+1:0] exp_q[$];
  logic [W-1:0] m_y = '0;

  mux4_reg #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .d0      (d0),
    .d1      (d1),
    .d2      (d2),
    .d3      (d3),
    .s0      (s0),
    .s1      (s1),
`ifdef MUX4_REG_PARITY_EN
    .y_par   (y_par),
`endif
    .y       (y),
    .y_valid (y_valid)
  );

  // Clock and reset-time defaults
  always #5 clk = ~clk;

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    s0  = 1'b0;
    s1  = 1'b0;
    d0  = '0;
    d1  = '0;
    d2  = '0;
    d3  = '0;
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pick the word by numeric select index, reset wins, hold when idle.
  always @(posedge clk) begin
    logic [W-1:0] words [4];
    logic [W-1:0] nxt;
    logic         vld;
    int           idx;
    words[0] = d0;
    words[1] = d1;
    words[2] = d2;
    words[3] = d3;
    idx = 2 * int'(s1) + int'(s0);
    if (rst) begin
      nxt = '0;
      vld = 1'b0;
    end else if (en) begin
      nxt = words[idx];
      vld = 1'b1;
    end else begin
      nxt = m_y;
      vld = 1'b0;
    end
    m_y <= nxt;
    exp_q.push_back({vld, ^nxt, nxt});
  end

  // Scoreboard: compare every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [W+1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("model_y", y, e[W-1:0]);
      chk("model_valid", W'(y_valid), W'(e[W+1]));
`ifdef MUX4_REG_PARITY_EN
      chk("model_par", W'(y_par), W'(e[W]));
`endif
    end
  end

  task automatic set_d(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] e);
    d0 = a;
    d1 = b;
    d2 = c;
    d3 = e;
  endtask

  // Drive one cycle, then check hand-computed results after the edge.
  task automatic cyc(input string nm, input logic r, input logic e, input logic [1:0] sel,
                     input logic [W-1:0] ey, input logic ev, input logic ep);
    rst = r;
    en  = e;
    s1  = sel[1];
    s0  = sel[0];
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_y"}, y, ey);
    chk({nm, "_valid"}, W'(y_valid), W'(ev));
`ifdef MUX4_REG_PARITY_EN
    chk({nm, "_par"}, W'(y_par), W'(ep));
`else
    if (ep !== ep) $display("unreachable");
`endif
  endtask

  initial begin
    set_d(4'd6, 4'd7, 4'd9, 4'd3);
    // Reset with en high
    cyc("rst0", 1'b1, 1'b1, 2'b11, 4'd0, 1'b0, 1'b0);
    cyc("rst1", 1'b1, 1'b1, 2'b11, 4'd0, 1'b0, 1'b0);
    // Select sweep
    cyc("sel00", 1'b0, 1'b1, 2'b00, 4'd6, 1'b1, 1'b0);
    cyc("sel10", 1'b0, 1'b1, 2'b10, 4'd9, 1'b1, 1'b0);
    cyc("sel01", 1'b0, 1'b1, 2'b01, 4'd7, 1'b1, 1'b1);
    cyc("sel11", 1'b0, 1'b1, 2'b11, 4'd3, 1'b1, 1'b0);
    // Hold with select and data disturbed
    set_d(4'd6, 4'd7, 4'd9, 4'hF);
    cyc("hold", 1'b0, 1'b0, 2'b00, 4'd3, 1'b0, 1'b0);
    cyc("hold2", 1'b0, 1'b0, 2'b11, 4'd3, 1'b0, 1'b0);
    cyc("resume", 1'b0, 1'b1, 2'b00, 4'd6, 1'b1, 1'b0);
    set_d(4'd6, 4'd7, 4'd9, 4'd3);
    // Reset priority over a load
    cyc("pre_rst", 1'b0, 1'b1, 2'b10, 4'd9, 1'b1, 1'b0);
    cyc("rst_pri", 1'b1, 1'b1, 2'b11, 4'd0, 1'b0, 1'b0);
    cyc("post_rst", 1'b0, 1'b1, 2'b11, 4'd3, 1'b1, 1'b0);
    // Data change under a fixed select
    cyc("fix_d1a", 1'b0, 1'b1, 2'b01, 4'd7, 1'b1, 1'b1);
    d1 = 4'hA;
    cyc("fix_d1b", 1'b0, 1'b1, 2'b01, 4'hA, 1'b1, 1'b0);
    // Idle after reset: no load until en rises
    cyc("rst_idle", 1'b1, 1'b0, 2'b01, 4'd0, 1'b0, 1'b0);
    cyc("idle", 1'b0, 1'b0, 2'b01, 4'd0, 1'b0, 1'b0);
    cyc("first_ld", 1'b0, 1'b1, 2'b10, 4'd9, 1'b1, 1'b0);
    // Random tail checked by the model only
    for (int i = 0; i < 40; i++) begin
      rst = ($urandom_range(0, 9) == 0);
      en  = ($urandom_range(0, 3) != 0);
      s1  = 1'($urandom_range(0, 1));
      s0  = 1'($urandom_range(0, 1));
      set_d(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
            W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
      @(posedge clk);
      @(negedge clk);
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
